// File: rtl/freq_pio_poller.sv
// Avalon-MM read master that polls a 32-bit PIO slave every PERIOD_CYCLES clocks,
// publishes each word as a sample, flags changes and block-averages 2^AVG_LOG2 samples.
module freq_pio_poller #(
  parameter int PERIOD_CYCLES = 50000,
  parameter int READ_ADDR     = 0,
  parameter int AVG_LOG2      = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic [31:0] sample,
  output logic        sample_valid,
  output logic        sample_changed,
  output logic [31:0] avg,
  output logic        avg_valid,
  output logic [1:0]  o_dbg_state
);

  // Handshakes: avm_read is a one-cycle strobe with no waitrequest and readdata is
  // valid exactly one cycle later; sample_valid/avg_valid are one-cycle pulses with
  // no back-pressure, the data buses hold their value between pulses.

  localparam int ACC_W = 32 + AVG_LOG2;
  localparam int CW    = AVG_LOG2 + 1;
  localparam int TW    = $clog2(PERIOD_CYCLES);
  localparam logic [CW-1:0] BLK_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WAIT} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_capture;
  logic [TW-1:0]      r_timer;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_sum;
  logic [CW-1:0]      r_cnt;
  logic               r_first;
  logic               r_read;
  logic [31:0]        r_sample;
  logic               r_sample_valid;
  logic               r_sample_changed;
  logic [31:0]        r_avg;
  logic               r_avg_valid;

  assign w_sum = r_acc + ACC_W'(avm_readdata);

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE:    if (enable) w_next_state = ISSUE;
      ISSUE:   w_next_state = enable ? CAPTURE : IDLE;
      CAPTURE: begin
        if (!enable) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT;
          w_capture    = 1'b1;
        end
      end
      WAIT: begin
        if (!enable)           w_next_state = IDLE;
        else if (r_timer == '0) w_next_state = ISSUE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer          <= '0;
      r_acc            <= '0;
      r_cnt            <= '0;
      r_first          <= 1'b0;
      r_read           <= 1'b0;
      r_sample         <= '0;
      r_sample_valid   <= 1'b0;
      r_sample_changed <= 1'b0;
      r_avg            <= '0;
      r_avg_valid      <= 1'b0;
    end else begin
      r_read           <= (w_next_state == ISSUE);
      r_sample_valid   <= 1'b0;
      r_sample_changed <= 1'b0;
      r_avg_valid      <= 1'b0;
      if (r_state == IDLE) begin
        // Any partial block from a previous run is dropped here.
        r_first <= 1'b1;
        r_acc   <= '0;
        r_cnt   <= '0;
      end
      if (w_capture) begin
        r_sample         <= avm_readdata;
        r_sample_valid   <= 1'b1;
        r_sample_changed <= !r_first && (avm_readdata != r_sample);
        r_first          <= 1'b0;
        r_timer          <= TW'(PERIOD_CYCLES - 3);
        if (r_cnt == BLK_LAST) begin
          r_avg       <= 32'(w_sum >> AVG_LOG2);
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_state == WAIT && r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
    end
  end

  assign avm_address    = 2'(READ_ADDR);
  assign avm_read       = r_read;
  assign sample         = r_sample;
  assign sample_valid   = r_sample_valid;
  assign sample_changed = r_sample_changed;
  assign avg            = r_avg;
  assign avg_valid      = r_avg_valid;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_freq_pio_poller.sv
// Scoreboard bench for freq_pio_poller: one instance with 4-sample blocks and one
// with AVG_LOG2=0, each fed by a registered latency-1 slave model.
module tb_freq_pio_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable, en0;
  logic [1:0]  avm_address, avm_address0;
  logic        avm_read, avm_read0;
  logic [31:0] avm_readdata = '0, avm_readdata0 = '0;
  logic [31:0] sample, sample0, avg, avg0;
  logic        sample_valid, sample_changed, avg_valid;
  logic        sample_valid0, sample_changed0, avg_valid0;
  logic [1:0]  dbg_state, dbg_state0;

  int checks = 0;
  int failures = 0;

  logic [32:0] exp_s_q[$];
  logic [31:0] exp_a_q[$];
  logic [32:0] exp_s0_q[$];
  logic [31:0] exp_a0_q[$];
  logic [31:0] sl_q[$];
  logic [31:0] sl0_q[$];

  int cyc = 0;
  int last_read = -1;
  int last_read_any = 0;
  logic prev_read = 1'b0;
  int sv_cnt = 0;
  int sv0_cnt = 0;

  freq_pio_poller #(.PERIOD_CYCLES(5), .READ_ADDR(0), .AVG_LOG2(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .sample(sample), .sample_valid(sample_valid), .sample_changed(sample_changed),
    .avg(avg), .avg_valid(avg_valid), .o_dbg_state(dbg_state)
  );

  freq_pio_poller #(.PERIOD_CYCLES(5), .READ_ADDR(0), .AVG_LOG2(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .enable(en0),
    .avm_address(avm_address0), .avm_read(avm_read0), .avm_readdata(avm_readdata0),
    .sample(sample0), .sample_valid(sample_valid0), .sample_changed(sample_changed0),
    .avg(avg0), .avg_valid(avg_valid0), .o_dbg_state(dbg_state0)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // latency-1 slave models
  always @(posedge clk) begin
    if (avm_read) avm_readdata <= (sl_q.size() != 0) ? sl_q.pop_front() : 32'hDEADBEEF;
    if (avm_read0) avm_readdata0 <= (sl0_q.size() != 0) ? sl0_q.pop_front() : 32'hDEADBEEF;
  end

  // monitor / scoreboard for the AVG_LOG2=2 instance
  always @(negedge clk) begin
    logic [32:0] es;
    logic [31:0] ea;
    cyc++;
    if (!reset_n) begin
      last_read = -1;
    end else begin
      if (avm_read) begin
        check("read_pulse_width", prev_read, 0);
        if (last_read >= 0) check("read_spacing", cyc - last_read, 5);
        last_read = cyc;
        last_read_any = cyc;
      end
      if (!enable) last_read = -1;
      if (sample_changed && !sample_valid) check("changed_without_valid", 1, 0);
      if (sample_valid) begin
        sv_cnt++;
        check("valid_latency", cyc - last_read_any, 2);
        if (exp_s_q.size() == 0) begin
          check("unexpected_sample", 1, 0);
        end else begin
          es = exp_s_q.pop_front();
          check("sample", sample, es[31:0]);
          check("sample_changed", sample_changed, es[32]);
        end
      end
      if (avg_valid) begin
        if (exp_a_q.size() == 0) begin
          check("unexpected_avg", 1, 0);
        end else begin
          ea = exp_a_q.pop_front();
          check("avg", avg, ea);
        end
      end
    end
    prev_read = avm_read;
  end

  // monitor / scoreboard for the AVG_LOG2=0 instance
  always @(negedge clk) begin
    logic [32:0] es;
    logic [31:0] ea;
    if (reset_n) begin
      if (sample_valid0 || avg_valid0) check("avg0_coincident", avg_valid0, sample_valid0);
      if (sample_valid0) begin
        sv0_cnt++;
        if (exp_s0_q.size() == 0) begin
          check("unexpected_sample0", 1, 0);
        end else begin
          es = exp_s0_q.pop_front();
          check("sample0", sample0, es[31:0]);
          check("sample_changed0", sample_changed0, es[32]);
        end
      end
      if (avg_valid0) begin
        if (exp_a0_q.size() == 0) begin
          check("unexpected_avg0", 1, 0);
        end else begin
          ea = exp_a0_q.pop_front();
          check("avg0", avg0, ea);
        end
      end
    end
  end

  task automatic wait_samples(input int which, input int n);
    int start;
    int got;
    start = (which == 0) ? sv_cnt : sv0_cnt;
    got = 0;
    for (int i = 0; i < 200 * n && got < n; i++) begin
      @(negedge clk);
      got = ((which == 0) ? sv_cnt : sv0_cnt) - start;
    end
    check("sample_count", got, n);
  endtask

  task automatic wait_read();
    int seen;
    seen = 0;
    for (int i = 0; i < 50 && seen == 0; i++) begin
      @(negedge clk);
      if (avm_read) seen = 1;
    end
    check("read_seen", seen, 1);
  endtask

  task automatic push_block(input logic [31:0] d0, d1, d2, d3,
                            input logic c1, c2, c3, input logic [31:0] a);
    sl_q.push_back(d0); sl_q.push_back(d1); sl_q.push_back(d2); sl_q.push_back(d3);
    exp_s_q.push_back({1'b0, d0}); exp_s_q.push_back({c1, d1});
    exp_s_q.push_back({c2, d2});   exp_s_q.push_back({c3, d3});
    exp_a_q.push_back(a);
  endtask

  task automatic run_block();
    @(posedge clk); #1 enable = 1'b1;
    wait_samples(0, 4);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; en0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", avm_read, 0);
    check("rst_sample", sample, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_changed", sample_changed, 0);
    check("rst_avg", avg, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_state", dbg_state, 0);
    check("address", avm_address, 0);
    @(negedge clk) reset_n = 1'b1;

    // constant 100: read one cycle after enable, period 5, no change flags
    push_block(100, 100, 100, 100, 0, 0, 0, 100);
    @(posedge clk); #1 enable = 1'b1;
    @(negedge clk) check("t1_no_early_read", avm_read, 0);
    @(negedge clk) check("t1_read_after_enable", avm_read, 1);
    wait_samples(0, 4);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);

    // 10,10,20,30 -> changes on 3 and 4, avg 70>>2 = 17
    push_block(10, 10, 20, 30, 0, 1, 1, 17);
    run_block();

    // all ones: sum exceeds 32 bits, mean is still all ones
    push_block(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF);
    run_block();

    // abort on the third read of a block; the partial sum must not leak
    sl_q.push_back(1); sl_q.push_back(2); sl_q.push_back(3);
    exp_s_q.push_back({1'b0, 32'd1}); exp_s_q.push_back({1'b1, 32'd2});
    @(posedge clk); #1 enable = 1'b1;
    wait_samples(0, 2);
    wait_read();
    enable = 1'b0;
    @(posedge clk); #1 check("t4_state_idle", dbg_state, 0);
    repeat (10) @(posedge clk);
    #1;
    check("t4_sample_hold", sample, 2);
    check("t4_avg_hold", avg, 32'hFFFFFFFF);
    push_block(4, 4, 4, 4, 0, 0, 0, 4);
    run_block();

    // AVG_LOG2=0 instance: avg follows every sample
    sl0_q.push_back(7); sl0_q.push_back(9);
    exp_s0_q.push_back({1'b0, 32'd7}); exp_s0_q.push_back({1'b1, 32'd9});
    exp_a0_q.push_back(7); exp_a0_q.push_back(9);
    @(posedge clk); #1 en0 = 1'b1;
    wait_samples(1, 2);
    @(posedge clk); #1 en0 = 1'b0;
    repeat (3) @(posedge clk);

    // reset while in CAPTURE: outputs clear at once, then polling restarts
    sl_q.push_back(55);
    @(posedge clk); #1 enable = 1'b1;
    wait_read();
    @(negedge clk);
    check("t6_in_capture", dbg_state, 2);
    reset_n = 1'b0;
    #1;
    check("t6_rst_read", avm_read, 0);
    check("t6_rst_sample", sample, 0);
    check("t6_rst_avg", avg, 0);
    check("t6_rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    sl_q.push_back(66);
    exp_s_q.push_back({1'b0, 32'd66});
    reset_n = 1'b1;
    @(negedge clk) check("t6_restart_read", avm_read, 1);
    wait_samples(0, 1);

    // reset during the read strobe drops avm_read without a clock
    wait_read();
    reset_n = 1'b0;
    #1 check("t6_async_read_drop", avm_read, 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    check("pending_samples", exp_s_q.size(), 0);
    check("pending_avgs", exp_a_q.size(), 0);
    check("pending_samples0", exp_s0_q.size(), 0);
    check("pending_avgs0", exp_a0_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_pio_poller.md
Name: freq_pio_poller

Overview:
- Avalon-MM read master that periodically polls a PIO-style 32-bit input slave, such as the frequency-count input ports, at a fixed word address.
- Fixed read latency of 1: the slave registers readdata from the address every clock, so readdata is valid the cycle after the address is presented.
- Each returned word is published as a sample, flagged when it differs from the previous one, and block-averaged over 2^AVG_LOG2 samples for fabric-side consumers (display, threshold logic).
- Sits between the fabric and the PIO slaves; no Nios involvement.

Parameters:
- PERIOD_CYCLES, 50000: clocks between successive avm_read strobes; legal minimum 3.
- READ_ADDR, 0: word address driven on avm_address (2 bits).
- AVG_LOG2, 2: log2 of samples per average block; legal range 0..8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = polling runs, 0 = stop and clear.
- avm_address  out  2  constant READ_ADDR.
- avm_read  out  1  registered read strobe, 1-cycle pulse.
- avm_readdata  in  32  slave data, valid the cycle after avm_read.
- sample  out  32  last captured word.
- sample_valid  out  1  1-cycle pulse when sample updates.
- sample_changed  out  1  1-cycle pulse, coincident with sample_valid, when the new sample differs from the previous one.
- avg  out  32  truncated mean of the last completed block.
- avg_valid  out  1  1-cycle pulse when avg updates.

Behaviour:
- Reset, asynchronous:
  - State goes to IDLE.
  - avm_read, sample, sample_valid, sample_changed, avg and avg_valid all go to 0.
  - Timer, accumulator, block counter and first flag all clear.
- States: IDLE, ISSUE, CAPTURE, WAIT.
- IDLE:
  - enable=1 -> ISSUE next cycle.
  - Sets first=1 and clears the accumulator and block counter.
- ISSUE:
  - avm_read=1 for exactly this cycle.
  - -> CAPTURE.
- CAPTURE:
  - avm_readdata is sampled at the end of this cycle.
  - The registered outputs update the following cycle:
    - sample <= readdata; sample_valid=1.
    - sample_changed = (!first && readdata != sample); then first<=0.
  - acc <= acc + readdata. acc width is 32+AVG_LOG2, so it cannot overflow.
  - On the 2^AVG_LOG2-th sample:
    - avg <= (acc + readdata) >> AVG_LOG2, truncated; avg_valid=1.
    - acc and block counter clear.
  - Loads timer with PERIOD_CYCLES-3; -> WAIT.
- WAIT:
  - Timer decrements each cycle; at timer==0 -> ISSUE.
  - WAIT therefore lasts PERIOD_CYCLES-2 cycles, giving an avm_read rising-edge spacing of exactly PERIOD_CYCLES.
- enable=0, sampled in any non-IDLE state:
  - -> IDLE next cycle.
  - An avm_read already asserted this cycle completes, but its data is discarded.
  - No sample_valid or avg_valid is produced for it.
  - Partial average block is discarded; sample and avg hold their last values.
- Re-enable restarts with a fresh block and first=1, so there is no sample_changed on the first sample.
- AVG_LOG2=0: avg equals sample, and avg_valid coincides with every sample_valid.
- All pulses are single-cycle; nothing is a level.
- Latency: avm_read cycle N -> sample_valid and avg_valid in cycle N+2.
- reset_n asserted mid-read: immediate return to reset values, and avm_read drops asynchronously.

Test Plan:
1. Reset then enable=1, PERIOD_CYCLES=5, slave returns 100 -> avm_read pulses 1 cycle after enable and every 5 cycles after; sample=100, sample_valid 2 cycles after each read; first sample_changed=0.
2. Slave returns 10, 10, 20, 30 with AVG_LOG2=2 -> sample_changed pulses only on samples 3 and 4; avg_valid once with avg=17 (70>>2 truncated).
3. Slave returns 0xFFFFFFFF four times, AVG_LOG2=2 -> avg=0xFFFFFFFF with no overflow; sample_changed=0 on samples 2-4.
4. Deassert enable on the avm_read cycle of sample 3 of a block -> no sample_valid for it; state IDLE; re-enable and feed 4, 4, 4, 4 -> avg=4 (old partial sum discarded).
5. AVG_LOG2=0, slave returns 7 then 9 -> avg_valid with every sample_valid; avg=7 then 9.
6. Assert reset_n low while in CAPTURE -> avm_read, sample and avg are 0 immediately; after release with enable=1, polling restarts from ISSUE.
